// File: rtl/hcsr04_ranger.sv
// HC-SR04 ultrasonic ranger: periodic trigger pulse, echo pulse timing, and conversion of echo width to cm.
// A result of 12'hFFF with timeout=1 means there was no echo or it ran out of range.
module hcsr04_ranger #(
   parameter int TRIG_CYCLES     = 500,
   parameter int CYCLES_PER_UNIT = 2900,
   parameter int TIMEOUT_CYCLES  = 1_500_000,
   parameter int PERIOD_CYCLES   = 3_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        echo,
   output logic        trig,
   output logic [11:0] distance,
   output logic        valid,
   output logic        timeout,
   output logic        busy
);

   localparam int PER_W = $clog2(PERIOD_CYCLES + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int SUB_W = $clog2(CYCLES_PER_UNIT + 1);
   localparam logic [PER_W-1:0] TRIG_LAST = PER_W'(TRIG_CYCLES - 1);
   localparam logic [PER_W-1:0] PER_LAST  = PER_W'(PERIOD_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(CYCLES_PER_UNIT - 1);

   typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLD} state_t;

   state_t            state, state_next;
   logic [PER_W-1:0]  per_cnt, per_next;
   logic [TMO_W-1:0]  tmo_cnt, tmo_next;
   logic [SUB_W-1:0]  sub_cnt, sub_next, sub_base;
   logic [11:0]       units, units_next, units_base;
   logic              echo_m, echo_s, echo_d;
   logic              count, result, result_tmo;

   // echo_d holds the previous synchronized sample so a rising edge needs a real low-to-high transition
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         echo_m <= 1'b0;
         echo_s <= 1'b0;
         echo_d <= 1'b0;
      end else begin
         echo_m <= echo;
         echo_s <= echo_m;
         echo_d <= echo_s;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         per_cnt <= '0;
         tmo_cnt <= '0;
         sub_cnt <= '0;
         units   <= '0;
      end else begin
         state   <= state_next;
         per_cnt <= per_next;
         tmo_cnt <= tmo_next;
         sub_cnt <= sub_next;
         units   <= units_next;
      end
   end

   always_comb begin
      state_next = state;
      per_next   = per_cnt;
      tmo_next   = tmo_cnt;
      sub_next   = sub_cnt;
      units_next = units;
      sub_base   = sub_cnt;
      units_base = units;
      count      = 1'b0;
      result     = 1'b0;
      result_tmo = 1'b0;
      case (state)
         IDLE: begin
            per_next = '0;
            if (enable) state_next = TRIG;
         end
         TRIG: begin
            per_next = per_cnt + 1'b1;
            if (per_cnt == TRIG_LAST) begin
               state_next = WAIT_RISE;
               tmo_next   = '0;
            end
         end
         WAIT_RISE: begin
            per_next = per_cnt + 1'b1;
            tmo_next = tmo_cnt + 1'b1;
            // The edge cycle itself is the first high cycle, so it is counted from a zero base
            if (echo_s && !echo_d) begin
               state_next = MEASURE;
               sub_base   = '0;
               units_base = '0;
               count      = 1'b1;
            end else if (tmo_cnt >= TMO_LAST) begin
               result     = 1'b1;
               result_tmo = 1'b1;
            end
         end
         MEASURE: begin
            per_next = per_cnt + 1'b1;
            tmo_next = tmo_cnt + 1'b1;
            if (!echo_s) begin
               result = 1'b1;
            end else begin
               count = 1'b1;
               if (tmo_cnt >= TMO_LAST) begin
                  result     = 1'b1;
                  result_tmo = 1'b1;
               end
            end
         end
         HOLD: begin
            if (per_cnt == PER_LAST) begin
               per_next   = '0;
               state_next = enable ? TRIG : IDLE;
            end else begin
               per_next = per_cnt + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase

      if (count) begin
         if (sub_base == SUB_LAST) begin
            sub_next   = '0;
            units_next = (units_base == 12'hFFF) ? units_base : units_base + 1'b1;
         end else begin
            sub_next   = sub_base + 1'b1;
            units_next = units_base;
         end
      end

      if (result) state_next = HOLD;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         trig     <= 1'b0;
         busy     <= 1'b0;
         valid    <= 1'b0;
         distance <= '0;
         timeout  <= 1'b0;
      end else begin
         trig  <= (state_next == TRIG);
         busy  <= (state_next != IDLE);
         valid <= result;
         if (result) begin
            distance <= result_tmo ? 12'hFFF : units;
            timeout  <= result_tmo;
         end
      end
   end

endmodule

// File: tb/tb_hcsr04_ranger.sv
// Self-checking bench for hcsr04_ranger: a reference model predicts distance, timeout and valid latency
// from the echo delay and width. One small instance and one saturation-oriented instance are exercised.
module tb_hcsr04_ranger;

   localparam int TRIG_A = 4;
   localparam int CPU_A  = 10;
   localparam int TMO_A  = 1000;
   localparam int PER_A  = 2000;
   localparam int CPU_B  = 1;
   localparam int TMO_B  = 9000;
   localparam int PER_B  = 20000;

   logic        clk;
   logic        reset;
   logic        enable_a, echo_a, trig_a, valid_a, timeout_a, busy_a;
   logic        enable_b, echo_b, trig_b, valid_b, timeout_b, busy_b;
   logic [11:0] distance_a, distance_b;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int last_rise = 0;

   hcsr04_ranger #(
      .TRIG_CYCLES(TRIG_A), .CYCLES_PER_UNIT(CPU_A), .TIMEOUT_CYCLES(TMO_A), .PERIOD_CYCLES(PER_A)
   ) dut_a (
      .clk(clk), .reset(reset), .enable(enable_a), .echo(echo_a), .trig(trig_a),
      .distance(distance_a), .valid(valid_a), .timeout(timeout_a), .busy(busy_a)
   );

   hcsr04_ranger #(
      .TRIG_CYCLES(TRIG_A), .CYCLES_PER_UNIT(CPU_B), .TIMEOUT_CYCLES(TMO_B), .PERIOD_CYCLES(PER_B)
   ) dut_b (
      .clk(clk), .reset(reset), .enable(enable_b), .echo(echo_b), .trig(trig_b),
      .distance(distance_b), .valid(valid_b), .timeout(timeout_b), .busy(busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: the logic sees echo two cycles late; a fall seen within the timeout window gives
   // floor(width/cpu) saturated at 4095, otherwise the result is a timeout delivered tmo cycles after trig fall.
   function automatic void model(input int delay, input int width, input int cpu, input int tmo,
                                 output logic [11:0] d, output logic t, output int lat);
      int fall_seen;
      int units;
      d   = 12'hFFF;
      t   = 1'b1;
      lat = tmo;
      if (delay >= 0 && width > 0) begin
         fall_seen = delay + width + 2;
         if (fall_seen <= tmo - 1) begin
            units = width / cpu;
            d     = (units > 4095) ? 12'hFFF : 12'(units);
            t     = 1'b0;
            lat   = fall_seen + 1;
         end
      end
   endfunction

   // Waits for the next trigger pulse, plays the echo relative to the trig fall, and reports the result.
   // Cycle index k counts negedges from the first one with trig low.
   task automatic do_measure(input bit sel_b, input int delay, input int width, input int limit,
                             input int drop_at, output int rise_at, output int lat, output int nvalid,
                             output logic [11:0] d, output logic t, output bit ok);
      int  n;
      int  k;
      int  post;
      bit  seen;
      ok = 1'b0; rise_at = 0; lat = -1; nvalid = 0; d = '0; t = 1'b0;
      n = 0;
      while ((sel_b ? trig_b : trig_a) !== 1'b1 && n < 25000) begin @(negedge clk); n++; end
      if ((sel_b ? trig_b : trig_a) !== 1'b1) return;
      rise_at = cyc;
      n = 0;
      while ((sel_b ? trig_b : trig_a) !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      if ((sel_b ? trig_b : trig_a) !== 1'b0) return;
      k = 0; post = 0; seen = 1'b0;
      while (k < limit && post < 4) begin
         if ((sel_b ? valid_b : valid_a) === 1'b1) begin
            nvalid++;
            if (!seen) begin
               seen = 1'b1;
               lat  = k;
               d    = sel_b ? distance_b : distance_a;
               t    = sel_b ? timeout_b : timeout_a;
            end
         end
         if (seen) post++;
         if (k == drop_at) begin
            if (sel_b) enable_b = 1'b0; else enable_a = 1'b0;
         end
         if (delay >= 0 && width > 0 && k == delay) begin
            if (sel_b) echo_b = 1'b1; else echo_a = 1'b1;
         end
         if (delay >= 0 && width > 0 && k == delay + width) begin
            if (sel_b) echo_b = 1'b0; else echo_a = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      ok = seen;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         echo_a = ~echo_a;
         echo_b = ~echo_b;
      end
      @(negedge clk);
      checks++; if (trig_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_trig got %0b want 0", trig_a); end
      checks++; if (distance_a !== 12'd0) begin errors++; $display("[TB] FAIL reset_distance got %0d want 0", distance_a); end
      checks++; if (valid_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b want 0", valid_a); end
      checks++; if (timeout_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout got %0b want 0", timeout_a); end
      checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b want 0", busy_a); end
      checks++; if (busy_b !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy_b got %0b want 0", busy_b); end
      echo_a = 1'b0;
      echo_b = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_distance();
      int rise, lat, nv, el;
      logic [11:0] d, ed;
      logic t, et;
      bit ok;
      enable_a = 1'b1;
      model(20, 250, CPU_A, TMO_A, ed, et, el);
      do_measure(1'b0, 20, 250, TMO_A + 60, -1, rise, lat, nv, d, t, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL dist_handshake got %0b want 1", ok); end
      checks++; if (d !== ed) begin errors++; $display("[TB] FAIL dist_value got %0d want %0d", d, ed); end
      checks++; if (t !== et) begin errors++; $display("[TB] FAIL dist_timeout got %0b want %0b", t, et); end
      checks++; if (nv !== 1) begin errors++; $display("[TB] FAIL dist_valid_pulses got %0d want 1", nv); end
      checks++; if (lat !== el) begin errors++; $display("[TB] FAIL dist_latency got %0d want %0d", lat, el); end
      last_rise = rise;
   endtask

   task automatic test_timeout_no_echo();
      int rise, lat, nv, el;
      logic [11:0] d, ed;
      logic t, et;
      bit ok;
      model(-1, 0, CPU_A, TMO_A, ed, et, el);
      do_measure(1'b0, -1, 0, TMO_A + 60, -1, rise, lat, nv, d, t, ok);
      checks++; if (rise - last_rise !== PER_A) begin errors++; $display("[TB] FAIL period_1 got %0d want %0d", rise - last_rise, PER_A); end
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL noecho_handshake got %0b want 1", ok); end
      checks++; if (d !== ed) begin errors++; $display("[TB] FAIL noecho_value got %0h want %0h", d, ed); end
      checks++; if (t !== et) begin errors++; $display("[TB] FAIL noecho_timeout got %0b want %0b", t, et); end
      checks++; if (lat !== el) begin errors++; $display("[TB] FAIL noecho_latency got %0d want %0d", lat, el); end
      last_rise = rise;
      model(30, 120, CPU_A, TMO_A, ed, et, el);
      do_measure(1'b0, 30, 120, TMO_A + 60, -1, rise, lat, nv, d, t, ok);
      checks++; if (rise - last_rise !== PER_A) begin errors++; $display("[TB] FAIL period_2 got %0d want %0d", rise - last_rise, PER_A); end
      checks++; if (d !== ed) begin errors++; $display("[TB] FAIL recover_value got %0d want %0d", d, ed); end
      checks++; if (t !== et) begin errors++; $display("[TB] FAIL recover_timeout got %0b want %0b", t, et); end
      checks++; if (nv !== 1) begin errors++; $display("[TB] FAIL recover_valid_pulses got %0d want 1", nv); end
   endtask

   task automatic test_stuck_high();
      int rise, lat, nv, el;
      logic [11:0] d, ed;
      logic t, et;
      bit ok;
      model(10, 5000, CPU_A, TMO_A, ed, et, el);
      do_measure(1'b0, 10, 5000, TMO_A + 60, -1, rise, lat, nv, d, t, ok);
      checks++; if (d !== ed) begin errors++; $display("[TB] FAIL stuck_value got %0h want %0h", d, ed); end
      checks++; if (t !== et) begin errors++; $display("[TB] FAIL stuck_timeout got %0b want %0b", t, et); end
      checks++; if (lat !== el) begin errors++; $display("[TB] FAIL stuck_latency got %0d want %0d", lat, el); end
      enable_a = 1'b0;
      repeat (4000) @(negedge clk);
      echo_a = 1'b0;
      checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL stuck_idle_busy got %0b want 0", busy_a); end
      echo_a = 1'b1;
      repeat (5) @(negedge clk);
      enable_a = 1'b1;
      model(-1, 0, CPU_A, TMO_A, ed, et, el);
      do_measure(1'b0, -1, 0, TMO_A + 60, -1, rise, lat, nv, d, t, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL prehigh_handshake got %0b want 1", ok); end
      checks++; if (d !== ed) begin errors++; $display("[TB] FAIL prehigh_value got %0h want %0h", d, ed); end
      checks++; if (t !== et) begin errors++; $display("[TB] FAIL prehigh_timeout got %0b want %0b", t, et); end
      echo_a = 1'b0;
   endtask

   task automatic test_random();
      int rise, lat, nv, el, delay, width;
      logic [11:0] d, ed;
      logic t, et;
      bit ok;
      for (int i = 0; i < 8; i++) begin
         delay = int'($urandom_range(300, 0));
         width = int'($urandom_range(1100, 1));
         model(delay, width, CPU_A, TMO_A, ed, et, el);
         do_measure(1'b0, delay, width, TMO_A + 60, -1, rise, lat, nv, d, t, ok);
         echo_a = 1'b0;
         checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL rand%0d_handshake got %0b want 1", i, ok); end
         checks++; if (d !== ed || t !== et) begin errors++; $display("[TB] FAIL rand%0d_result d=%0d w=%0d got %0d/%0b want %0d/%0b", i, delay, width, d, t, ed, et); end
         checks++; if (lat !== el) begin errors++; $display("[TB] FAIL rand%0d_latency got %0d want %0d", i, lat, el); end
         checks++; if (nv !== 1) begin errors++; $display("[TB] FAIL rand%0d_valid_pulses got %0d want 1", i, nv); end
      end
   endtask

   task automatic test_saturate();
      int rise, lat, nv, el;
      logic [11:0] d, ed;
      logic t, et;
      bit ok;
      enable_b = 1'b1;
      model(10, 5000, CPU_B, TMO_B, ed, et, el);
      do_measure(1'b1, 10, 5000, TMO_B + 60, -1, rise, lat, nv, d, t, ok);
      enable_b = 1'b0;
      echo_b   = 1'b0;
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL sat_handshake got %0b want 1", ok); end
      checks++; if (d !== ed) begin errors++; $display("[TB] FAIL sat_value got %0d want %0d", d, ed); end
      checks++; if (t !== et) begin errors++; $display("[TB] FAIL sat_timeout got %0b want %0b", t, et); end
      checks++; if (lat !== el) begin errors++; $display("[TB] FAIL sat_latency got %0d want %0d", lat, el); end
   endtask

   task automatic test_enable_drop();
      int rise, lat, nv, el, n, idle_at, trig_seen;
      logic [11:0] d, ed;
      logic t, et;
      bit ok;
      enable_a = 1'b1;
      model(15, 300, CPU_A, TMO_A, ed, et, el);
      do_measure(1'b0, 15, 300, TMO_A + 60, 40, rise, lat, nv, d, t, ok);
      checks++; if (d !== ed || t !== et) begin errors++; $display("[TB] FAIL drop_result got %0d/%0b want %0d/%0b", d, t, ed, et); end
      checks++; if (lat !== el) begin errors++; $display("[TB] FAIL drop_latency got %0d want %0d", lat, el); end
      n = 0;
      while (busy_a !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
      idle_at = cyc;
      checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL drop_busy_clear got %0b want 0", busy_a); end
      checks++; if (idle_at - rise !== PER_A) begin errors++; $display("[TB] FAIL drop_hold_length got %0d want %0d", idle_at - rise, PER_A); end
      trig_seen = 0;
      repeat (2500) begin
         @(negedge clk);
         if (trig_a === 1'b1) trig_seen++;
      end
      checks++; if (trig_seen !== 0) begin errors++; $display("[TB] FAIL drop_no_trig got %0d want 0", trig_seen); end
   endtask

   task automatic test_reset_in_measure();
      int n;
      enable_a = 1'b1;
      n = 0;
      while (trig_a !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      while (trig_a !== 1'b0 && n < 200) begin @(negedge clk); n++; end
      repeat (5) @(negedge clk);
      echo_a = 1'b1;
      repeat (20) @(negedge clk);
      checks++; if (busy_a !== 1'b1) begin errors++; $display("[TB] FAIL rstm_busy_before got %0b want 1", busy_a); end
      reset = 1'b1;
      #1;
      checks++; if (trig_a !== 1'b0) begin errors++; $display("[TB] FAIL rstm_trig got %0b want 0", trig_a); end
      checks++; if (valid_a !== 1'b0) begin errors++; $display("[TB] FAIL rstm_valid got %0b want 0", valid_a); end
      checks++; if (distance_a !== 12'd0) begin errors++; $display("[TB] FAIL rstm_distance got %0d want 0", distance_a); end
      checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL rstm_busy got %0b want 0", busy_a); end
      @(negedge clk);
      echo_a   = 1'b0;
      enable_a = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      reset    = 1'b1;
      enable_a = 1'b0;
      enable_b = 1'b0;
      echo_a   = 1'b0;
      echo_b   = 1'b0;
      test_reset();
      test_distance();
      test_timeout_no_echo();
      test_stuck_high();
      test_random();
      test_saturate();
      test_enable_drop();
      test_reset_in_measure();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
